// File: rtl/rv_dmem_ctrl.sv
// rtl/rv_dmem_ctrl.sv - RV32I load/store controller driving a single-port SRAM
// Optional: define RV_DMEM_CTRL_OOR_CHK_EN to flag addresses beyond the SRAM as errors.
module rv_dmem_ctrl #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 4
) (
  input  logic               i_dmem_ctrl_clk,
  input  logic               i_dmem_ctrl_rstn,
  input  logic               i_dmem_ctrl_req_val,
  output logic               o_dmem_ctrl_req_rdy,
  input  logic               i_dmem_ctrl_req_we,
  input  logic [31:0]        i_dmem_ctrl_req_addr,
  input  logic [1:0]         i_dmem_ctrl_req_size,
  input  logic               i_dmem_ctrl_req_unsigned,
  input  logic [31:0]        i_dmem_ctrl_req_wdata,
  output logic               o_dmem_ctrl_rsp_val,
  output logic [31:0]        o_dmem_ctrl_rsp_rdata,
  output logic               o_dmem_ctrl_rsp_err,
  output logic [BW_DATA-1:0] o_dmem_ctrl_sram_data,
  output logic [BW_ADDR-1:0] o_dmem_ctrl_sram_addr,
  output logic               o_dmem_ctrl_sram_cen,
  output logic               o_dmem_ctrl_sram_wen,
  output logic               o_dmem_ctrl_sram_ren,
  input  logic [BW_DATA-1:0] i_dmem_ctrl_sram_data,
  input  logic               i_dmem_ctrl_sram_data_val
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_RMW_RD, S_RMW_WR, S_RESP} state_t;
  state_t state, state_nxt;

  logic [BW_ADDR+1:0] addr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        word_q;
  logic               err_q;

  logic               accept;
  logic               req_err;
  logic               oor_err;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_val;
  logic [31:0]        merged;

  assign accept = i_dmem_ctrl_req_val && (state == S_IDLE);

`ifdef RV_DMEM_CTRL_OOR_CHK_EN
  assign oor_err = |i_dmem_ctrl_req_addr[31:BW_ADDR+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_dmem_ctrl_req_addr[31:BW_ADDR+2];
  assign oor_err = 1'b0;
`endif

  always_comb begin
    req_err = oor_err;
    case (i_dmem_ctrl_req_size)
      2'b01:   if (i_dmem_ctrl_req_addr[0]) req_err = 1'b1;
      2'b10:   if (i_dmem_ctrl_req_addr[1:0] != 2'b00) req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction and sign/zero extension straight off the combinational SRAM data.
  always_comb begin
    lane_b = i_dmem_ctrl_sram_data[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? i_dmem_ctrl_sram_data[31:16] : i_dmem_ctrl_sram_data[15:0];
    case (size_q)
      2'b00:   load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_val = i_dmem_ctrl_sram_data;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_nxt             = state;
    o_dmem_ctrl_sram_cen  = 1'b0;
    o_dmem_ctrl_sram_wen  = 1'b0;
    o_dmem_ctrl_sram_ren  = 1'b0;
    o_dmem_ctrl_sram_data = '0;
    case (state)
      S_IDLE: begin
        if (i_dmem_ctrl_req_val) begin
          if (req_err)                          state_nxt = S_RESP;
          else if (!i_dmem_ctrl_req_we)         state_nxt = S_READ;
          else if (i_dmem_ctrl_req_size == 2'b10) state_nxt = S_WRITE;
          else                                  state_nxt = S_RMW_RD;
        end
      end
      S_READ: begin
        o_dmem_ctrl_sram_cen = 1'b1;
        o_dmem_ctrl_sram_ren = 1'b1;
        if (i_dmem_ctrl_sram_data_val) state_nxt = S_RESP;
      end
      S_WRITE: begin
        o_dmem_ctrl_sram_cen  = 1'b1;
        o_dmem_ctrl_sram_wen  = 1'b1;
        o_dmem_ctrl_sram_data = wdata_q;
        state_nxt             = S_RESP;
      end
      S_RMW_RD: begin
        o_dmem_ctrl_sram_cen = 1'b1;
        o_dmem_ctrl_sram_ren = 1'b1;
        if (i_dmem_ctrl_sram_data_val) state_nxt = S_RMW_WR;
      end
      S_RMW_WR: begin
        o_dmem_ctrl_sram_cen  = 1'b1;
        o_dmem_ctrl_sram_wen  = 1'b1;
        o_dmem_ctrl_sram_data = merged;
        state_nxt             = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // rdata_q is cleared on every accept so stores and errors respond with zero.
  always_ff @(posedge i_dmem_ctrl_clk or negedge i_dmem_ctrl_rstn) begin
    if (!i_dmem_ctrl_rstn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= i_dmem_ctrl_req_addr[BW_ADDR+1:0];
        size_q  <= i_dmem_ctrl_req_size;
        uns_q   <= i_dmem_ctrl_req_unsigned;
        wdata_q <= i_dmem_ctrl_req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == S_READ && i_dmem_ctrl_sram_data_val)   rdata_q <= load_val;
      if (state == S_RMW_RD && i_dmem_ctrl_sram_data_val) word_q  <= i_dmem_ctrl_sram_data;
    end
  end

  assign o_dmem_ctrl_req_rdy   = (state == S_IDLE);
  assign o_dmem_ctrl_rsp_val   = (state == S_RESP);
  assign o_dmem_ctrl_rsp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
  assign o_dmem_ctrl_rsp_err   = (state == S_RESP) && err_q;
  assign o_dmem_ctrl_sram_addr = addr_q[BW_ADDR+1:2];

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// tb/tb_rv_dmem_ctrl.sv - self-checking bench for rv_dmem_ctrl against a byte-level memory model
module tb_rv_dmem_ctrl;
  localparam int BW_DATA = 32;
  localparam int BW_ADDR = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_val = 1'b0;
  logic req_rdy;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0] req_size = '0;
  logic req_uns = 1'b0;
  logic [31:0] req_wdata = '0;
  logic rsp_val;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  logic [BW_DATA-1:0] sram_wd;
  logic [BW_ADDR-1:0] sram_addr;
  logic cen, wen, ren;
  logic [BW_DATA-1:0] sram_rd;
  logic dval = 1'b0;

  bit [31:0] mem [16];
  bit [7:0] ref_mem [64];

  int n_checks = 0;
  int n_fail = 0;

  int obs_lat, obs_ren, obs_wen, obs_cen, obs_both, obs_rdy_busy;
  bit obs_got, obs_err, obs_rdy_idle, obs_val_idle;
  logic [31:0] obs_rdata, obs_wdata;
  logic [3:0] obs_waddr;

  rv_dmem_ctrl #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_dmem_ctrl_clk(clk),
    .i_dmem_ctrl_rstn(rstn),
    .i_dmem_ctrl_req_val(req_val),
    .o_dmem_ctrl_req_rdy(req_rdy),
    .i_dmem_ctrl_req_we(req_we),
    .i_dmem_ctrl_req_addr(req_addr),
    .i_dmem_ctrl_req_size(req_size),
    .i_dmem_ctrl_req_unsigned(req_uns),
    .i_dmem_ctrl_req_wdata(req_wdata),
    .o_dmem_ctrl_rsp_val(rsp_val),
    .o_dmem_ctrl_rsp_rdata(rsp_rdata),
    .o_dmem_ctrl_rsp_err(rsp_err),
    .o_dmem_ctrl_sram_data(sram_wd),
    .o_dmem_ctrl_sram_addr(sram_addr),
    .o_dmem_ctrl_sram_cen(cen),
    .o_dmem_ctrl_sram_wen(wen),
    .o_dmem_ctrl_sram_ren(ren),
    .i_dmem_ctrl_sram_data(sram_rd),
    .i_dmem_ctrl_sram_data_val(dval)
  );

  always #5 clk = ~clk;

  assign sram_rd = mem[sram_addr];
  always @(posedge clk) if (cen && wen) mem[sram_addr] <= sram_wd;

  // Reference model: byte-addressed memory, wrapping at the SRAM size.
  function automatic bit m_err(input logic [31:0] a, input logic [1:0] s);
    bit e;
    e = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
`ifdef RV_DMEM_CTRL_OOR_CHK_EN
    if (a >= 32'd64) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input bit u);
    logic [31:0] v;
    int base, n;
    base = int'(a % 64);
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (!u && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
    int base, n;
    base = int'(a % 64);
    n = 1 << s;
    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8 * i +: 8];
  endfunction

  function automatic logic [31:0] m_word(input int idx);
    return {ref_mem[4 * idx + 3], ref_mem[4 * idx + 2], ref_mem[4 * idx + 1], ref_mem[4 * idx]};
  endfunction

  // Issues one request and records what the DUT did until its response (or a timeout).
  task automatic drive(input bit we, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata, input int stall);
    @(negedge clk);
    obs_rdy_idle = req_rdy;
    obs_val_idle = rsp_val;
    req_val = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_uns = uns; req_wdata = wdata; dval = 1'b0;
    @(posedge clk);
    obs_lat = 0; obs_ren = 0; obs_wen = 0; obs_cen = 0; obs_both = 0; obs_rdy_busy = 0;
    obs_got = 1'b0; obs_err = 1'b0; obs_rdata = '0; obs_wdata = '0; obs_waddr = '0;
    while (!obs_got && obs_lat < 40) begin
      @(negedge clk);
      req_val = 1'b0;
      obs_lat++;
      if (cen) obs_cen++;
      if (cen && ren) begin obs_ren++; dval = (obs_ren > stall); end
      if (cen && wen) begin obs_wen++; obs_wdata = sram_wd; obs_waddr = sram_addr; end
      if (wen && ren) obs_both++;
      if (req_rdy) obs_rdy_busy++;
      if (rsp_val) begin obs_got = 1'b1; obs_rdata = rsp_rdata; obs_err = rsp_err; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({req_rdy, rsp_val, rsp_err, cen, wen, ren} !== 6'b100000) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected 100000", {req_rdy, rsp_val, rsp_err, cen, wen, ren}); end
    n_checks++; if ({rsp_rdata, sram_wd, sram_addr} !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", rsp_rdata, sram_wd, sram_addr); end
    rstn = 1'b1;
  endtask

  task automatic test_word_store_load();
    drive(1'b1, 32'h8, 2'b10, 1'b0, 32'hDEADBEEF, 0);
    m_store(32'h8, 2'b10, 32'hDEADBEEF);
    n_checks++; if (obs_wen !== 1 || obs_waddr !== 4'd2 || obs_wdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL sw_write: got wen=%0d addr=%0d data=%h expected 1/2/deadbeef", obs_wen, obs_waddr, obs_wdata); end
    n_checks++; if (obs_lat !== 2 || obs_err !== 1'b0 || obs_ren !== 0) begin n_fail++;
      $display("FAIL sw_rsp: got lat=%0d err=%0d ren=%0d expected 2/0/0", obs_lat, obs_err, obs_ren); end
    drive(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 0);
    n_checks++; if (obs_lat !== 2 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin n_fail++;
      $display("FAIL lw_rsp: got lat=%0d rdata=%h err=%0d expected 2/deadbeef/0", obs_lat, obs_rdata, obs_err); end
  endtask

  task automatic test_byte_rmw();
    drive(1'b1, 32'h8, 2'b10, 1'b0, 32'h11223344, 0);
    m_store(32'h8, 2'b10, 32'h11223344);
    drive(1'b1, 32'h9, 2'b00, 1'b0, 32'h5A5A5AAB, 0);
    m_store(32'h9, 2'b00, 32'h5A5A5AAB);
    n_checks++; if (obs_ren !== 1 || obs_wen !== 1 || obs_both !== 0) begin n_fail++;
      $display("FAIL rmw_strobes: got ren=%0d wen=%0d both=%0d expected 1/1/0", obs_ren, obs_wen, obs_both); end
    n_checks++; if (obs_wdata !== 32'h1122AB44 || obs_waddr !== 4'd2) begin n_fail++;
      $display("FAIL rmw_data: got %h@%0d expected 1122ab44@2", obs_wdata, obs_waddr); end
    n_checks++; if (obs_lat !== 3 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin n_fail++;
      $display("FAIL rmw_rsp: got lat=%0d rdata=%h err=%0d expected 3/0/0", obs_lat, obs_rdata, obs_err); end
  endtask

  task automatic test_extension();
    logic [31:0] t_addr [4] = '{32'h2, 32'h2, 32'h2, 32'h0};
    logic [1:0]  t_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    bit          t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_exp  [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
    drive(1'b1, 32'h0, 2'b10, 1'b0, 32'h80FF7F01, 0);
    m_store(32'h0, 2'b10, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, t_addr[i], t_size[i], t_uns[i], 32'h0, 0);
      n_checks++; if (obs_rdata !== t_exp[i] || obs_lat !== 2) begin n_fail++;
        $display("FAIL ext_%0d: got %h lat=%0d expected %h lat=2", i, obs_rdata, obs_lat, t_exp[i]); end
    end
  endtask

  task automatic test_misalign();
    logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr [3] = '{32'h6, 32'h3, 32'h0};
    logic [1:0]  t_size [3] = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      drive(t_we[i], t_addr[i], t_size[i], 1'b0, $urandom, 0);
      n_checks++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_cen !== 0) begin n_fail++;
        $display("FAIL misalign_%0d: got lat=%0d err=%0d rdata=%h cen=%0d expected 1/1/0/0",
                 i, obs_lat, obs_err, obs_rdata, obs_cen); end
    end
  endtask

  task automatic test_read_wait();
    drive(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 3);
    n_checks++; if (obs_ren !== 4 || obs_rdy_busy !== 0) begin n_fail++;
      $display("FAIL wait_ren: got ren=%0d rdy_busy=%0d expected 4/0", obs_ren, obs_rdy_busy); end
    n_checks++; if (obs_lat !== obs_ren + 1 || obs_rdata !== m_load(32'h8, 2'b10, 1'b0)) begin n_fail++;
      $display("FAIL wait_rsp: got lat=%0d rdata=%h expected %0d/%h", obs_lat, obs_rdata, obs_ren + 1,
               m_load(32'h8, 2'b10, 1'b0)); end
  endtask

  task automatic test_reset_mid_rmw();
    int wen_seen, rsp_seen, rdy_low;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_val = 1'b1; req_we = 1'b1; req_addr = 32'h5; req_size = 2'b00; req_wdata = 32'hCC; dval = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    n_checks++; if (ren !== 1'b1 || cen !== 1'b1) begin n_fail++;
      $display("FAIL mid_rmw_rd: got ren=%b cen=%b expected 1/1", ren, cen); end
    rstn = 1'b0;
    #1;
    n_checks++; if ({cen, wen, ren, rsp_val, req_rdy} !== 5'b00001) begin n_fail++;
      $display("FAIL mid_rst_async: got %b expected 00001", {cen, wen, ren, rsp_val, req_rdy}); end
    repeat (2) @(negedge clk);
    rstn = 1'b1; dval = 1'b1;
    wen_seen = 0; rsp_seen = 0; rdy_low = 0;
    repeat (6) begin
      @(negedge clk);
      if (wen) wen_seen++;
      if (rsp_val) rsp_seen++;
      if (!req_rdy) rdy_low++;
    end
    n_checks++; if (wen_seen !== 0 || rsp_seen !== 0 || rdy_low !== 0) begin n_fail++;
      $display("FAIL mid_rst_after: got wen=%0d rsp=%0d rdy_low=%0d expected 0/0/0", wen_seen, rsp_seen, rdy_low); end
    drive(1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 0);
    n_checks++; if (obs_rdata !== m_load(32'h4, 2'b10, 1'b0)) begin n_fail++;
      $display("FAIL mid_rst_mem: got %h expected %h", obs_rdata, m_load(32'h4, 2'b10, 1'b0)); end
    exp_rd = m_err(32'h100, 2'b10) ? 32'h0 : m_load(32'h100, 2'b10, 1'b0);
    drive(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0);
    n_checks++; if (obs_err !== m_err(32'h100, 2'b10) || obs_rdata !== exp_rd) begin n_fail++;
      $display("FAIL oor_load: got err=%0d rdata=%h expected %0d/%h", obs_err, obs_rdata,
               m_err(32'h100, 2'b10), exp_rd); end
  endtask

  task automatic test_random();
    bit we, uns, e;
    logic [1:0] size;
    logic [31:0] addr, wdata, exp_rd, exp_wd;
    int stall, exp_lat, exp_ren, exp_wen;
    for (int it = 0; it < 80; it++) begin
      we = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      wdata = $urandom;
      stall = $urandom_range(0, 3);
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && size != 2'b11) addr = addr & ~((32'd1 << size) - 1);
      if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 255)) << 8);
      e = m_err(addr, size);
      exp_rd = (!we && !e) ? m_load(addr, size, uns) : 32'h0;
      exp_lat = e ? 1 : (!we ? 2 + stall : (size == 2'b10 ? 2 : 3 + stall));
      exp_ren = (e || (we && size == 2'b10)) ? 0 : stall + 1;
      exp_wen = (we && !e) ? 1 : 0;
      drive(we, addr, size, uns, wdata, stall);
      if (we && !e) m_store(addr, size, wdata);
      exp_wd = m_word(int'(addr[5:2]));
      n_checks++; if (obs_rdy_idle !== 1'b1 || obs_val_idle !== 1'b0) begin n_fail++;
        $display("FAIL rnd_idle_%0d: got rdy=%0d val=%0d expected 1/0", it, obs_rdy_idle, obs_val_idle); end
      n_checks++; if (obs_got !== 1'b1 || obs_lat !== exp_lat) begin n_fail++;
        $display("FAIL rnd_lat_%0d: got got=%0d lat=%0d expected 1/%0d", it, obs_got, obs_lat, exp_lat); end
      n_checks++; if (obs_err !== e || obs_rdata !== exp_rd) begin n_fail++;
        $display("FAIL rnd_rsp_%0d: got err=%0d rdata=%h expected %0d/%h", it, obs_err, obs_rdata, e, exp_rd); end
      n_checks++; if (obs_ren !== exp_ren || obs_wen !== exp_wen || obs_both !== 0 || obs_rdy_busy !== 0) begin n_fail++;
        $display("FAIL rnd_strb_%0d: got ren=%0d wen=%0d both=%0d rdy=%0d expected %0d/%0d/0/0",
                 it, obs_ren, obs_wen, obs_both, obs_rdy_busy, exp_ren, exp_wen); end
      if (exp_wen == 1) begin
        n_checks++; if (obs_wdata !== exp_wd || obs_waddr !== addr[5:2]) begin n_fail++;
          $display("FAIL rnd_wr_%0d: got %h@%0d expected %h@%0d", it, obs_wdata, obs_waddr, exp_wd, addr[5:2]); end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_extension();
    test_misalign();
    test_read_wait();
    test_reset_mid_rmw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_dmem_ctrl.md
Name: rv_dmem_ctrl

Overview:
- Initiator-side controller that drives a single-port SRAM (cen/wen/ren, word address, combinational read data plus data-valid) on behalf of the RV32I load/store stage.
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Checks alignment, does read-modify-write for byte/halfword stores, and extracts plus sign/zero-extends load data.
- Returns one response pulse per accepted request.

Parameters:
- BW_DATA, 32, SRAM word width; fixed at 32 for RV32I, other values unsupported.
- BW_ADDR, 4, SRAM word-address width; SRAM holds 2**BW_ADDR words.

Ports:
- i_dmem_ctrl_clk  in  1  clock
- i_dmem_ctrl_rstn  in  1  asynchronous active-low reset
- i_dmem_ctrl_req_val  in  1  request valid
- o_dmem_ctrl_req_rdy  out  1  request ready; high only in IDLE
- i_dmem_ctrl_req_we  in  1  1 = store, 0 = load
- i_dmem_ctrl_req_addr  in  32  byte address
- i_dmem_ctrl_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_dmem_ctrl_req_unsigned  in  1  load zero-extend when 1
- i_dmem_ctrl_req_wdata  in  32  store data, right-aligned
- o_dmem_ctrl_rsp_val  out  1  one-cycle response pulse
- o_dmem_ctrl_rsp_rdata  out  32  load result; 0 for stores and errors
- o_dmem_ctrl_rsp_err  out  1  misaligned, reserved size, or (optional) out-of-range
- o_dmem_ctrl_sram_data  out  BW_DATA  SRAM write data
- o_dmem_ctrl_sram_addr  out  BW_ADDR  SRAM word address = req_addr[BW_ADDR+1:2]
- o_dmem_ctrl_sram_cen  out  1  SRAM chip enable
- o_dmem_ctrl_sram_wen  out  1  SRAM write enable
- o_dmem_ctrl_sram_ren  out  1  SRAM read enable
- i_dmem_ctrl_sram_data  in  BW_DATA  SRAM read data (combinational on address)
- i_dmem_ctrl_sram_data_val  in  1  SRAM read data valid

Behaviour:
- Reset clocks and polarity: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE. All registered fields (address, size, unsigned, wdata, captured rdata, error) are 0. Every output is 0 except req_rdy, which is 1.
- FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
- Request acceptance: a request is accepted on req_val & req_rdy in IDLE, and all request fields are registered at that edge. req_rdy is 0 in every other state; there is no request queue.
- Error check at accept: size=11, half with addr[0]=1, or word with addr[1:0]!=0 sets err and moves IDLE->RESP. No SRAM strobe is issued for an erroring request.
- Non-error request routing:
  - load -> READ
  - word store -> WRITE
  - byte/half store -> RMW_RD
- READ:
  - Drive cen=1, ren=1, addr.
  - If sram_data_val=1: capture the extracted, extended lane and go to RESP.
  - Otherwise hold READ with strobes asserted.
- WRITE: drive cen=1, wen=1, data=wdata for one cycle, then go to RESP.
- RMW_RD: same as READ, except the full word is captured when sram_data_val=1, then go to RMW_WR.
- RMW_WR: drive cen=1, wen=1, data = captured word with the target lane replaced.
  - Byte: lane addr[1:0], source wdata[7:0].
  - Half: lane addr[1], source wdata[15:0].
  - Then go to RESP.
- RESP: rsp_val=1 for exactly one cycle, with rdata/err valid. Then go to IDLE.
- Load extraction:
  - Byte: lane addr[1:0]; sign-extend from bit 7 unless unsigned.
  - Half: lane addr[1]; sign-extend from bit 15 unless unsigned.
  - Word: passed through; unsigned is ignored.
- SRAM strobes are 0 in IDLE and RESP. wen and ren are never both 1.
- Latency, counted in cycles after the accept edge to rsp_val, assuming data_val is immediate:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Throughput: the next accept occurs no earlier than the cycle after RESP.
- Reset mid-operation: the FSM returns to IDLE immediately, no further strobes are driven, and a pending response is dropped.

Optional Feature:
- Macro: RV_DMEM_CTRL_OOR_CHK_EN.
- Defined: a request with any bit of addr[31:BW_ADDR+2] set is flagged err=1 at accept. It takes the error path (no SRAM access, rsp_val 1 cycle later, rdata=0). This check is ORed with the alignment error.
- Undefined: the upper address bits are ignored and the address wraps modulo 2**(BW_ADDR+2) bytes.

Test Plan:
- Word store, then load: store addr=0x8, wdata=0xDEADBEEF; load addr=0x8, size=10. Expect wen pulse with sram_addr=2. Expect rsp_val 2 cycles after the load accept, rdata=0xDEADBEEF, err=0.
- Byte RMW: word 2 holds 0x11223344; store byte addr=0x9, wdata=0xAB. Expect one ren cycle, then one wen cycle with data=0x1122AB44, rsp_val at accept+3.
- Sign/zero extension: word=0x80FF7F01. lb addr=0x2 -> 0xFFFFFFFF. lbu addr=0x2 -> 0x000000FF. lh addr=0x2 -> 0xFFFF80FF. lhu addr=0x0 -> 0x00007F01.
- Misalign: lw addr=0x6 and sh addr=0x3. Each gives rsp_val at accept+1, err=1, rdata=0, and cen stays 0 throughout.
- Read wait: hold sram_data_val=0 for 3 cycles during a load. Expect ren held high for 4 cycles, req_rdy=0, and rsp_val 1 cycle after data_val rises.
- Reset mid-RMW: assert rstn=0 while in RMW_RD. Expect outputs cleared asynchronously, no wen after release, req_rdy=1, and with OOR_CHK_EN a load to addr=0x100 returns err=1.
